// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings for the data RAM arbiter between the CPU data port and the debug master.
package data_mem_arbiter_pkg;

    localparam int unsigned MEMCTL_WIDTH = 4;
    localparam int unsigned MEMCTL_WRITE = 0;
    localparam int unsigned RUN_WIDTH    = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_DBG_ACK = 1'b1
    } state_e;

endpackage

// File: rtl/data_mem_arbiter_run_counter.sv
// Saturating count of contended CPU grants; reaching MAX_CPU_RUN forces a debug slot.
module arb_run_counter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_CPU_RUN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam logic [RUN_WIDTH-1:0] MAX_CNT = RUN_WIDTH'(MAX_CPU_RUN);

    logic [RUN_WIDTH-1:0] run_count_q;
    logic [RUN_WIDTH-1:0] run_count_d;

    assign at_max = (run_count_q == MAX_CNT);

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        run_count_d = run_count_q;
        if (clr) begin
            run_count_d = '0;
        end else if (inc && !at_max) begin
            run_count_d = run_count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_count_q <= '0;
        end else begin
            run_count_q <= run_count_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data RAM between the CPU data port (single-cycle when uncontended)
// and a req/ack debug master whose wait is bounded by a CPU run counter.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_CPU_RUN = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic [MEMCTL_WIDTH-1:0] cpu_memory_control,
    input  logic [ADDR_WIDTH-1:0]   cpu_adr,
    input  logic [DATA_WIDTH-1:0]   cpu_write_data,
    output logic [DATA_WIDTH-1:0]   cpu_read_data,
    output logic                    cpu_stall,
    input  logic                    dbg_req,
    input  logic [MEMCTL_WIDTH-1:0] dbg_memory_control,
    input  logic [ADDR_WIDTH-1:0]   dbg_adr,
    input  logic [DATA_WIDTH-1:0]   dbg_write_data,
    output logic                    dbg_ack,
    output logic [DATA_WIDTH-1:0]   dbg_read_data,
    output logic [MEMCTL_WIDTH-1:0] ram_memory_control,
    output logic [ADDR_WIDTH-1:0]   ram_adr,
    output logic [DATA_WIDTH-1:0]   ram_write_data,
    input  logic [DATA_WIDTH-1:0]   ram_read_data
);

    state_e                  state_q;
    state_e                  state_d;
    owner_e                  owner;
    logic                    dbg_elig;
    logic                    at_max;
    logic                    run_clr;
    logic                    run_inc;
    logic [DATA_WIDTH-1:0]   dbg_read_data_q;
    logic [DATA_WIDTH-1:0]   dbg_read_data_d;

    // Debug is not arbitrated during its ack cycle, so a still-high dbg_req cannot double-grant.
    assign dbg_elig = dbg_req && (state_q == ST_IDLE);

    // Owner selection; reset forces no owner so nothing is written while reset is low.
    always_comb begin
        owner = OWN_NONE;
        if (!reset) begin
            owner = OWN_NONE;
        end else if (cpu_req && dbg_elig) begin
            owner = at_max ? OWN_DBG : OWN_CPU;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (dbg_elig) begin
            owner = OWN_DBG;
        end
    end

    // RAM port mux driven by the current owner.
    always_comb begin
        ram_memory_control = '0;
        ram_adr            = '0;
        ram_write_data     = '0;
        case (owner)
            OWN_CPU: begin
                ram_memory_control = cpu_memory_control;
                ram_adr            = cpu_adr;
                ram_write_data     = cpu_write_data;
            end
            OWN_DBG: begin
                ram_memory_control = dbg_memory_control;
                ram_adr            = dbg_adr;
                ram_write_data     = dbg_write_data;
            end
            default: ;
        endcase
    end

    assign cpu_stall     = reset && cpu_req && (owner != OWN_CPU);
    assign cpu_read_data = ram_read_data;
    assign dbg_ack       = (state_q == ST_DBG_ACK);
    assign dbg_read_data = dbg_read_data_q;

    assign run_inc = (owner == OWN_CPU) && dbg_elig;
    assign run_clr = (owner == OWN_DBG) || ((state_q == ST_IDLE) && !dbg_req);

    arb_run_counter #(
        .MAX_CPU_RUN (MAX_CPU_RUN)
    ) u_run (
        .clock  (clock),
        .reset  (reset),
        .clr    (run_clr),
        .inc    (run_inc),
        .at_max (at_max)
    );

    // Next state and debug read capture (pre-write word on debug writes).
    always_comb begin
        state_d         = state_q;
        dbg_read_data_d = dbg_read_data_q;
        case (state_q)
            ST_IDLE:    if (owner == OWN_DBG) state_d = ST_DBG_ACK;
            ST_DBG_ACK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (owner == OWN_DBG) begin
            dbg_read_data_d = ram_read_data;
        end
    end

    // State and debug read data registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            dbg_read_data_q <= '0;
        end else begin
            state_q         <= state_d;
            dbg_read_data_q <= dbg_read_data_d;
        end
    end

endmodule
